// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to a one-cycle-latency ROM and
// buffers responses in a two-entry FIFO presented to decode, with redirect and fault handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        reset,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_size,
    output logic        mem_en,
    input  logic [31:0] mem_data,
    input  logic        mem_exception,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_exception,
    output logic [31:0] exc_pc
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    entry_t      head;
    entry_t      tail;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic        issue_ok;
    logic        fault_issue;
    logic [2:0]  occupancy;
    entry_t      incoming;

    assign pop       = instr_valid & instr_ready;
    assign push      = inflight & ~redirect;
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign incoming  = '{instr: mem_data, pc: inflight_pc};

    // NOTE: every variable written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        issue       = 1'b0;

        // Slots already claimed (buffered + in flight) minus the one leaving this cycle
        // must leave room for the new response.
        if (reset && state == RUN && !redirect && (occupancy < DEPTH + {2'b00, pop}))
            issue = 1'b1;

        fault_issue = issue & mem_exception;
        issue_ok    = issue & ~mem_exception;

        if (redirect)
            state_next = (redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
        else if (fault_issue)
            state_next = FAULT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            state <= RUN;
        else
            state <= state_next;
    end

    // NOTE: the FIFO slots are reset as well so instr/instr_pc read zero after reset
    // rather than whatever was last buffered.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            head        <= '0;
            tail        <= '0;
            count       <= 2'd0;
            exc_pc      <= 32'h0;
        end else if (redirect) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            if (redirect_pc[1:0] == 2'b00)
                pc <= redirect_pc;
            else
                exc_pc <= redirect_pc;
        end else begin
            inflight <= issue_ok;
            if (issue_ok) begin
                pc          <= pc + 32'd4;
                inflight_pc <= pc;
            end
            if (fault_issue)
                exc_pc <= pc;

            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        head <= incoming;
                    else
                        tail <= incoming;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= incoming;
                    end else begin
                        head <= tail;
                        tail <= incoming;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en          = issue;
    assign mem_addr        = pc;
    assign mem_size        = 3'b010;
    assign instr           = head.instr;
    assign instr_pc        = head.pc;
    assign instr_valid     = (count != 2'd0);
    assign fetch_exception = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, stall, redirect, misaligned
// redirect, ROM fault, address wrap and mid-operation reset.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [2:0]  mem_size;
    logic        mem_en;
    logic [31:0] mem_data = 32'h0;
    logic        mem_exception;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_exception;
    logic [31:0] exc_pc;

    logic        fault_arm;
    logic [31:0] fault_addr;

    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_size        (mem_size),
        .mem_en          (mem_en),
        .mem_data        (mem_data),
        .mem_exception   (mem_exception),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .fetch_exception (fetch_exception),
        .exc_pc          (exc_pc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0010_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge CLK)
        if (mem_en) mem_data <= rom(mem_addr);

    assign mem_exception = fault_arm && (mem_addr == fault_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, 32'(instr_valid), 32'd1);
        check({tag, ".pc"}, instr_pc, pc);
        check({tag, ".instr"}, instr, rom(pc));
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        fault_arm   = 1'b0;
        fault_addr  = 32'h0;

        // Reset state
        tick; tick;
        check("rst.valid", 32'(instr_valid), 32'd0);
        check("rst.instr", instr, 32'h0);
        check("rst.pc", instr_pc, 32'h0);
        check("rst.mem_en", 32'(mem_en), 32'd0);
        check("rst.fexc", 32'(fetch_exception), 32'd0);
        check("rst.exc_pc", exc_pc, 32'h0);
        check("rst.size", 32'(mem_size), 32'd2);

        // Release and stream at one per cycle
        reset = 1'b1;
        #1;
        check("rel.mem_en", 32'(mem_en), 32'd1);
        check("rel.addr", mem_addr, 32'h0);
        tick;
        check("c1.valid", 32'(instr_valid), 32'd0);
        check("c1.addr", mem_addr, 32'h4);
        tick; check_head("c2", 32'h0);
        tick; check_head("c3", 32'h4);
        tick; check_head("c4", 32'h8);

        // Decode stall: buffer fills, issue stops, head held
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            check_head("stall", 32'h8);
            check("stall.mem_en", 32'(mem_en), 32'd0);
        end
        instr_ready = 1'b1;
        #1;
        check("resume.mem_en", 32'(mem_en), 32'd1);
        check("resume.addr", mem_addr, 32'h10);
        tick; check_head("resume0", 32'hC);
        tick; check_head("resume1", 32'h10);
        tick; check_head("resume2", 32'h14);

        // Redirect with buffered and inflight data
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("redir.mem_en", 32'(mem_en), 32'd0);
        tick;
        check("redir.valid", 32'(instr_valid), 32'd0);
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("redir.mem_en1", 32'(mem_en), 32'd1);
        check("redir.addr", mem_addr, 32'h40);
        tick;
        check("redir.valid1", 32'(instr_valid), 32'd0);
        tick; check_head("redir0", 32'h40);
        tick; check_head("redir1", 32'h44);

        // Misaligned redirect enters FAULT
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        tick;
        redirect = 1'b0;
        #1;
        check("mis.fexc", 32'(fetch_exception), 32'd1);
        check("mis.exc_pc", exc_pc, 32'h42);
        check("mis.mem_en", 32'(mem_en), 32'd0);
        check("mis.valid", 32'(instr_valid), 32'd0);
        tick;
        check("mis.fexc1", 32'(fetch_exception), 32'd1);
        check("mis.mem_en1", 32'(mem_en), 32'd0);

        // Aligned redirect recovers
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        tick;
        redirect = 1'b0;
        #1;
        check("rec.fexc", 32'(fetch_exception), 32'd0);
        check("rec.mem_en", 32'(mem_en), 32'd1);
        check("rec.addr", mem_addr, 32'h8);
        tick;
        tick; check_head("rec0", 32'h8);
        tick; check_head("rec1", 32'hC);

        // ROM fault on issue; older entry still drains
        fault_addr = 32'h14;
        fault_arm  = 1'b1;
        #1;
        check("mexc.mem_en", 32'(mem_en), 32'd1);
        check("mexc.addr", mem_addr, 32'h14);
        tick;
        fault_arm = 1'b0;
        #1;
        check("mexc.fexc", 32'(fetch_exception), 32'd1);
        check("mexc.exc_pc", exc_pc, 32'h14);
        check("mexc.mem_en1", 32'(mem_en), 32'd0);
        check_head("mexc.drain", 32'h10);
        tick;
        check("mexc.empty", 32'(instr_valid), 32'd0);
        check("mexc.fexc1", 32'(fetch_exception), 32'd1);

        // Address wrap at top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick;
        redirect = 1'b0;
        #1;
        check("wrap.fexc", 32'(fetch_exception), 32'd0);
        check("wrap.mem_en", 32'(mem_en), 32'd1);
        check("wrap.addr0", mem_addr, 32'hFFFF_FFF8);
        tick;
        check("wrap.addr1", mem_addr, 32'hFFFF_FFFC);
        tick;
        check("wrap.addr2", mem_addr, 32'h0);
        check_head("wrap0", 32'hFFFF_FFF8);
        tick; check_head("wrap1", 32'hFFFF_FFFC);
        tick; check_head("wrap2", 32'h0);

        // Reset asserted with the buffer full
        instr_ready = 1'b0;
        tick;
        check_head("full", 32'h0);
        check("full.mem_en", 32'(mem_en), 32'd0);
        reset = 1'b0;
        #1;
        check("arst.valid", 32'(instr_valid), 32'd0);
        check("arst.instr", instr, 32'h0);
        check("arst.pc", instr_pc, 32'h0);
        check("arst.mem_en", 32'(mem_en), 32'd0);
        check("arst.fexc", 32'(fetch_exception), 32'd0);
        check("arst.exc_pc", exc_pc, 32'h0);
        tick;
        reset       = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("rerel.mem_en", 32'(mem_en), 32'd1);
        check("rerel.addr", mem_addr, 32'h0);
        tick;
        check("rerel.valid", 32'(instr_valid), 32'd0);
        tick; check_head("rerel0", 32'h0);
        tick; check_head("rerel1", 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, fixed 2: output buffer entries; other values are unsupported.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 mem_addr  output  32  byte address to the instruction ROM.
REQ-006 mem_size  output  3  access size; constant 3'b010 (word).
REQ-007 mem_en  output  1  read request strobe; ROM returns data one cycle later.
REQ-008 mem_data  input  32  ROM read data, valid the cycle after mem_en=1.
REQ-009 mem_exception  input  1  ROM access fault, combinational in the request cycle.
REQ-010 instr  output  32  instruction at the FIFO head.
REQ-011 instr_pc  output  32  address of instr.
REQ-012 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-013 instr_ready  input  1  decode accepts the head this cycle.
REQ-014 redirect  input  1  branch/jump taken; flush and refetch.
REQ-015 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-016 fetch_exception  output  1  fetch fault pending (level).
REQ-017 exc_pc  output  32  faulting fetch address.

Function
REQ-018 State machine, states RUN and FAULT; reset enters RUN.
REQ-019 Registers: pc (next issue address), inflight flag plus its address, 2-entry FIFO of {instr, pc}, count 0..2.
REQ-020 Issue condition in RUN: redirect=0 and count + inflight - (instr_valid & instr_ready) < 2; mem_en equals the issue condition, mem_addr equals pc.
REQ-021 On issue, pc <= pc + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), and inflight <= 1 with the issued address.
REQ-022 When inflight=1 and no redirect, mem_data and the inflight address are pushed into the FIFO that edge; inflight clears unless a new issue occurs.
REQ-023 Handshake: transfer occurs when instr_valid & instr_ready; the head pops; push and pop in the same cycle are both honoured.
REQ-024 instr/instr_pc/instr_valid come from the FIFO head registers; they do not change while instr_valid=1 and instr_ready=0.
REQ-025 Sustained throughput is 1 instruction/cycle with instr_ready held high; first instr_valid appears 2 cycles after reset release.
REQ-026 redirect=1 (any state): FIFO flushed (count <= 0), inflight response discarded, mem_en=0 that cycle, pc <= redirect_pc; redirect has priority over push, pop and issue.
REQ-027 redirect_pc[1:0] != 0: state <= FAULT, exc_pc <= redirect_pc, pc unchanged.
REQ-028 mem_exception=1 while mem_en=1: no inflight set, state <= FAULT, exc_pc <= mem_addr; FIFO contents older than the fault remain drainable.
REQ-029 FAULT: mem_en=0, fetch_exception=1, FIFO drains normally; exit to RUN only on redirect with aligned redirect_pc.
REQ-030 instr_ready while instr_valid=0 has no effect.

Reset
REQ-031 reset=0 asynchronously forces: state RUN, pc RESET_PC, count 0, inflight 0, instr_valid 0, instr 0, instr_pc 0, fetch_exception 0, exc_pc 0, mem_en 0.
REQ-032 Reset asserted mid-operation discards all buffered and inflight data; no instr_valid pulse until 2 cycles after release.

Verification
REQ-033 Release reset, ROM word0=32'h00000013, word1=32'h00100093, instr_ready=1 -> cycle 2 instr=00000013 pc 0, cycle 3 instr=00100093 pc 4, one per cycle.
REQ-034 instr_ready=0 for 5 cycles after first valid -> count reaches 2, mem_en=0, instr held stable; ready=1 resumes with no lost or duplicated pc.
REQ-035 redirect=1, redirect_pc=32'h40 while FIFO full and inflight -> next cycle instr_valid=0, mem_addr=32'h40; first valid instr_pc=32'h40, older entries never presented.
REQ-036 redirect_pc=32'h42 -> fetch_exception=1, exc_pc=32'h42, mem_en=0; subsequent redirect to 32'h8 -> RUN, fetch from 32'h8.
REQ-037 pc=32'hFFFF_FFFC issued -> next mem_addr=32'h0000_0000.
REQ-038 reset pulsed low while count=2 -> outputs at REQ-031 values immediately; refetch from RESET_PC.
